// File: rtl/qupls4_reservation_station_pkg.sv
// Shared types for the Qupls4 reservation station: dispatcher entry format,
// writeback bus bundle and default station depth.
package qupls4_reservation_station_pkg;

    localparam int unsigned ROB_ENTRIES     = 16;
    localparam int unsigned RNDX_W          = $clog2(ROB_ENTRIES);
    localparam int unsigned RS_WID          = 64;
    localparam int unsigned RS_NENTRIES_DEF = 4;

    typedef logic [RNDX_W-1:0] rob_ndx_t;

    typedef struct packed {
        logic [3:0]  funcunit;
        rob_ndx_t    rndx;
        logic [31:0] ins;
        logic        argA_v;
        logic [63:0] argA;
        logic        argB_v;
        logic [63:0] argB;
        logic        argC_v;
        logic [63:0] argC;
        logic        argD_v;
        logic [63:0] argD;
    } reservation_station_entry_t;

    typedef struct packed {
        logic              v;
        logic [8:0]        preg;
        logic [RS_WID-1:0] val;
    } rs_wb_bus_t;

endpackage

// File: rtl/qupls4_rs_age_matrix.sv
// Age matrix for the reservation station. age_q[i][j] set means slot j is
// older than slot i. A row is loaded on allocate, a column is cleared on free.
module qupls4_rs_age_matrix #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] alloc_i,
    input  logic [N-1:0] free_i,
    input  logic [N-1:0] valid_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] oldest_o
);

    logic [N-1:0][N-1:0] age_q, age_d;

    // Next-state rows and one-hot oldest among the request vector.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            // Newly allocated slot is younger than every surviving resident.
            age_d[i]    = alloc_i[i] ? (valid_i & ~free_i) : (age_q[i] & ~free_i);
            oldest_o[i] = req_i[i] && !(|(age_q[i] & req_i));
        end
    end

    // Age matrix state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/qupls4_reservation_station.sv
// Per-functional-unit reservation station: accepts one dispatched entry per
// cycle, snoops writeback buses for missing operands and issues ready entries.
// Option: QUPLS4_RS_AGE_ORDER_EN issues the oldest ready slot (age matrix);
// without it the lowest-index ready slot issues.
module qupls4_reservation_station
    import qupls4_reservation_station_pkg::*;
#(
    parameter logic [3:0]  FUNCUNIT = 4'd0,
    parameter int unsigned NENTRIES = RS_NENTRIES_DEF,
    parameter int unsigned NWB      = 4,
    parameter int unsigned WID      = RS_WID
) (
    input  logic                             clk,
    input  logic                             rst,
    input  reservation_station_entry_t [3:0] rse_i,
    input  logic [3:0]                       rse_v,
    input  logic [ROB_ENTRIES-1:0]           stomp,
    input  logic [NWB-1:0]                   wb_v,
    input  logic [NWB-1:0][8:0]              wb_preg,
    input  logic [NWB-1:0][WID-1:0]          wb_val,
    output logic                             busy,
    output reservation_station_entry_t       issue_o,
    output logic                             issue_v,
    input  logic                             issue_rdy
);

    localparam int unsigned CW = $clog2(NENTRIES + 1);

    rs_wb_bus_t [NWB-1:0]                      wb;
    reservation_station_entry_t [NENTRIES-1:0] slot_q, slot_d;
    logic [NENTRIES-1:0] valid_q, valid_d;
    logic [NENTRIES-1:0] free_oh, alloc, ready, stomped, sel_oh, freed;
    logic [3:0]          hit;
    logic [1:0]          lane;
    logic                hit_any;
    logic [CW-1:0]       n_occ, free_cnt;

    // Capture one operand from the lowest-numbered matching writeback bus.
    function automatic logic [64:0] snoop(input logic v, input logic [63:0] arg,
                                          input rs_wb_bus_t [NWB-1:0] b);
        logic [64:0] r;
        r = {v, arg};
        for (int j = int'(NWB) - 1; j >= 0; j--) begin
            if (!v && b[j].v && b[j].preg == arg[8:0]) r = {1'b1, b[j].val};
        end
        return r;
    endfunction

    function automatic reservation_station_entry_t wake(input reservation_station_entry_t e,
                                                        input rs_wb_bus_t [NWB-1:0] b);
        reservation_station_entry_t r;
        r = e;
        {r.argA_v, r.argA} = snoop(e.argA_v, e.argA, b);
        {r.argB_v, r.argB} = snoop(e.argB_v, e.argB, b);
        {r.argC_v, r.argC} = snoop(e.argC_v, e.argC, b);
        {r.argD_v, r.argD} = snoop(e.argD_v, e.argD, b);
        return r;
    endfunction

    // Bundle the writeback buses.
    always_comb begin
        for (int j = 0; j < NWB; j++) begin
            wb[j].v    = wb_v[j];
            wb[j].preg = wb_preg[j];
            wb[j].val  = wb_val[j];
        end
    end

    // Dispatch lane match; lowest hitting lane wins.
    always_comb begin
        hit  = '0;
        lane = '0;
        for (int k = 3; k >= 0; k--) begin
            hit[k] = rse_v[k] && (rse_i[k].funcunit == FUNCUNIT);
            if (hit[k]) lane = 2'(k);
        end
        hit_any = |hit;
    end

    // Lowest free slot, occupancy and busy back-pressure.
    always_comb begin
        free_oh = '0;
        n_occ   = '0;
        for (int i = int'(NENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end else begin
                n_occ = n_occ + CW'(1);
            end
        end
        free_cnt = CW'(NENTRIES) - n_occ;
        alloc    = hit_any ? free_oh : '0;
        // Dispatcher registers busy, so one free slot with a hit already counts as full.
        busy     = (free_cnt == '0) || (free_cnt == CW'(1) && hit_any);
    end

    // Ready and stomp status per slot.
    always_comb begin
        for (int i = 0; i < NENTRIES; i++) begin
            stomped[i] = valid_q[i] && stomp[slot_q[i].rndx];
            ready[i]   = valid_q[i] && !stomped[i] && slot_q[i].argA_v && slot_q[i].argB_v
                         && slot_q[i].argC_v && slot_q[i].argD_v;
        end
    end

`ifdef QUPLS4_RS_AGE_ORDER_EN
    qupls4_rs_age_matrix #(
        .N (NENTRIES)
    ) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc_i  (alloc),
        .free_i   (freed),
        .valid_i  (valid_q),
        .req_i    (ready),
        .oldest_o (sel_oh)
    );
`else
    // Lowest-index ready slot is selected.
    always_comb begin
        sel_oh = '0;
        for (int i = int'(NENTRIES) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end
`endif

    // Issue mux, slot release and next slot contents.
    always_comb begin
        issue_v = |ready;
        issue_o = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (sel_oh[i]) issue_o = slot_q[i];
        end
        freed   = (issue_rdy ? sel_oh : '0) | stomped;
        valid_d = (valid_q & ~freed) | alloc;
        for (int i = 0; i < NENTRIES; i++) begin
            slot_d[i] = alloc[i] ? wake(rse_i[lane], wb) : wake(slot_q[i], wb);
        end
    end

    // Slot state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    // More than one lane targeting this unit in a cycle is a dispatcher bug.
    a_single_hit: assert property (@(posedge clk) disable iff (!rst) $onehot0(hit));

endmodule

// File: tb/tb_qupls4_reservation_station.sv
// Self-checking bench for qupls4_reservation_station: directed scenarios plus
// randomized traffic checked against a slot/sequence-number reference model.
module tb_qupls4_reservation_station;
    import qupls4_reservation_station_pkg::*;

    localparam logic [3:0] FU = 4'd0;

    logic                             clk = 1'b0;
    logic                             rst;
    reservation_station_entry_t [3:0] rse_i;
    logic [3:0]                       rse_v;
    logic [ROB_ENTRIES-1:0]           stomp;
    logic [3:0]                       wb_v;
    logic [3:0][8:0]                  wb_preg;
    logic [3:0][63:0]                 wb_val;
    logic                             busy;
    reservation_station_entry_t       issue_o;
    logic                             issue_v;
    logic                             issue_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: four slots, each with an arrival sequence number.
    reservation_station_entry_t m_e[4];
    bit                         m_v[4];
    int unsigned                m_seq[4];
    int unsigned                seq_ctr;
    bit                         m_busy;

    qupls4_reservation_station #(
        .FUNCUNIT (FU),
        .NENTRIES (4),
        .NWB      (4),
        .WID      (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rse_i     (rse_i),
        .rse_v     (rse_v),
        .stomp     (stomp),
        .wb_v      (wb_v),
        .wb_preg   (wb_preg),
        .wb_val    (wb_val),
        .busy      (busy),
        .issue_o   (issue_o),
        .issue_v   (issue_v),
        .issue_rdy (issue_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ent(input string tag, input reservation_station_entry_t obs,
                             input reservation_station_entry_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic reservation_station_entry_t mk(input int rndx, input logic [3:0] vm,
                                                      input logic [8:0] tag);
        reservation_station_entry_t e;
        e          = '0;
        e.funcunit = FU;
        e.rndx     = rob_ndx_t'(rndx);
        e.ins      = $urandom;
        e.argA_v   = vm[0];
        e.argA     = vm[0] ? {$urandom, $urandom} : {55'd0, tag};
        e.argB_v   = vm[1];
        e.argB     = vm[1] ? {$urandom, $urandom} : {55'd0, tag};
        e.argC_v   = vm[2];
        e.argC     = vm[2] ? {$urandom, $urandom} : {55'd0, tag};
        e.argD_v   = vm[3];
        e.argD     = vm[3] ? {$urandom, $urandom} : {55'd0, tag};
        return e;
    endfunction

    // Operand capture: first bus (lowest j) carrying the tag supplies the value.
    function automatic logic [64:0] cap(input logic v, input logic [63:0] a);
        if (v) return {1'b1, a};
        for (int j = 0; j < 4; j++) begin
            if (wb_v[j] && wb_preg[j] == a[8:0]) return {1'b1, wb_val[j]};
        end
        return {1'b0, a};
    endfunction

    function automatic reservation_station_entry_t mwake(input reservation_station_entry_t e);
        reservation_station_entry_t r;
        r = e;
        {r.argA_v, r.argA} = cap(e.argA_v, e.argA);
        {r.argB_v, r.argB} = cap(e.argB_v, e.argB);
        {r.argC_v, r.argC} = cap(e.argC_v, e.argC);
        {r.argD_v, r.argD} = cap(e.argD_v, e.argD);
        return r;
    endfunction

    function automatic bit m_rdy(input int i);
        return m_v[i] && m_e[i].argA_v && m_e[i].argB_v && m_e[i].argC_v && m_e[i].argD_v
               && !stomp[m_e[i].rndx];
    endfunction

    function automatic int m_sel();
        int s;
        s = -1;
        for (int i = 0; i < 4; i++) begin
            if (m_rdy(i)) begin
`ifdef QUPLS4_RS_AGE_ORDER_EN
                if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
                if (s < 0) s = i;
`endif
            end
        end
        return s;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_v[i]   = 1'b0;
            m_e[i]   = '0;
            m_seq[i] = 0;
        end
        seq_ctr = 0;
        m_busy  = 1'b0;
    endtask

    task automatic idle();
        rse_v   = '0;
        rse_i   = '0;
        stomp   = '0;
        wb_v    = '0;
        wb_preg = '0;
        wb_val  = '0;
    endtask

    // Inputs already driven at the falling edge: check outputs, advance model one clock.
    task automatic step();
        int s, nfree, lane, fslot;
        bit hit, exp_busy;
        reservation_station_entry_t exp_e;
        #1;
        s     = m_sel();
        nfree = 0;
        fslot = -1;
        for (int i = 3; i >= 0; i--) begin
            if (!m_v[i]) begin
                nfree++;
                fslot = i;
            end
        end
        hit  = 1'b0;
        lane = 0;
        for (int k = 3; k >= 0; k--) begin
            if (rse_v[k] && rse_i[k].funcunit == FU) begin
                hit  = 1'b1;
                lane = k;
            end
        end
        exp_busy = (nfree == 0) || (nfree == 1 && hit);
        exp_e    = '0;
        if (s >= 0) exp_e = m_e[s];
        check("issue_v", 64'(issue_v), 64'(s >= 0));
        check_ent("issue_o", issue_o, exp_e);
        check("busy", 64'(busy), 64'(exp_busy));
        m_busy = exp_busy;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i]) begin
                if ((i == s && issue_rdy) || stomp[m_e[i].rndx]) m_v[i] = 1'b0;
                else m_e[i] = mwake(m_e[i]);
            end
        end
        if (hit && fslot >= 0) begin
            m_e[fslot]   = mwake(rse_i[lane]);
            m_v[fslot]   = 1'b1;
            m_seq[fslot] = seq_ctr;
            seq_ctr++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        stomp = '1;
        step();
        idle();
    endtask

    initial begin
        int h;
        rst       = 1'b0;
        issue_rdy = 1'b0;
        idle();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_issue_v", 64'(issue_v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_ent("rst_issue_o", issue_o, '0);
        @(negedge clk);
        rst = 1'b1;

        // Lane 2 dispatch, all args valid: issues next cycle.
        issue_rdy = 1'b1;
        rse_i[2]  = mk(5, 4'hF, 9'h0);
        rse_v     = 4'b0100;
        step();
        idle();
        #1;
        check("t1_issue_v", 64'(issue_v), 64'd1);
        check("t1_rndx", 64'(issue_o.rndx), 64'd5);
        step();
        #1;
        check("t1_freed", 64'(issue_v), 64'd0);
        step();

        // argB waits on preg 0x05a, supplied two cycles later.
        rse_i[0] = mk(6, 4'b1101, 9'h05a);
        rse_v    = 4'b0001;
        step();
        idle();
        step();
        wb_v[1]    = 1'b1;
        wb_preg[1] = 9'h05a;
        wb_val[1]  = 64'hDEAD_BEEF;
        #1;
        check("t2_wait", 64'(issue_v), 64'd0);
        step();
        idle();
        #1;
        check("t2_issue_v", 64'(issue_v), 64'd1);
        check("t2_argB", issue_o.argB, 64'hDEAD_BEEF);
        step();

        // Writeback in the dispatch cycle must not be lost.
        rse_i[0]   = mk(2, 4'b1110, 9'h011);
        rse_v      = 4'b0001;
        wb_v[2]    = 1'b1;
        wb_preg[2] = 9'h011;
        wb_val[2]  = 64'h1234_5678_9ABC_DEF0;
        step();
        idle();
        #1;
        check("t3_issue_v", 64'(issue_v), 64'd1);
        check("t3_argA", issue_o.argA, 64'h1234_5678_9ABC_DEF0);
        step();

        // Fill the station with issue blocked, then drain.
        drain();
        issue_rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            idle();
            rse_i[n] = mk(8 + n, 4'hF, 9'h0);
            rse_v[n] = 1'b1;
            #1;
            check("t4_busy_fill", 64'(busy), 64'(n == 3));
            step();
        end
        idle();
        issue_rdy = 1'b1;
        #1;
        check("t4_busy_full", 64'(busy), 64'd1);
        step();
        #1;
        check("t4_busy_after_hs", 64'(busy), 64'd0);
        for (int n = 0; n < 4; n++) step();

`ifdef QUPLS4_RS_AGE_ORDER_EN
        // rndx 7 sits in a higher slot than younger rndx 3 but must issue first.
        drain();
        issue_rdy = 1'b0;
        rse_i[0]  = mk(1, 4'b1110, 9'h1F0);
        rse_v     = 4'b0001;
        step();
        idle();
        rse_i[1] = mk(7, 4'hF, 9'h0);
        rse_v    = 4'b0010;
        step();
        idle();
        stomp[1] = 1'b1;
        step();
        idle();
        rse_i[3] = mk(3, 4'hF, 9'h0);
        rse_v    = 4'b1000;
        step();
        idle();
        #1;
        check("t5_oldest", 64'(issue_o.rndx), 64'd7);
        step();
        issue_rdy = 1'b1;
        stomp[3]  = 1'b1;
        #1;
        check("t5_oldest_hs", 64'(issue_o.rndx), 64'd7);
        step();
        idle();
        #1;
        check("t5_stomped", 64'(issue_v), 64'd0);
        step();
`endif

        // Randomized traffic against the model.
        drain();
        for (int c = 0; c < 600; c++) begin
            idle();
            issue_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                rse_i[k]          = mk(int'($urandom_range(0, 15)), 4'($urandom),
                                       9'($urandom_range(0, 15)));
                rse_i[k].funcunit = 4'($urandom_range(1, 15));
                rse_v[k]          = 1'($urandom_range(0, 1));
            end
            if (!m_busy && $urandom_range(0, 1) == 1) begin
                h                 = int'($urandom_range(0, 3));
                rse_i[h].funcunit = FU;
                rse_v[h]          = 1'b1;
            end
            for (int j = 0; j < 4; j++) begin
                wb_v[j]    = ($urandom_range(0, 2) == 0);
                wb_preg[j] = 9'($urandom_range(0, 15));
                wb_val[j]  = {$urandom, $urandom};
            end
            if ($urandom_range(0, 15) == 0) stomp[$urandom_range(0, 15)] = 1'b1;
            step();
        end

        // Asynchronous reset with three residents mid-handshake.
        drain();
        issue_rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            idle();
            rse_i[0] = mk(9 + n, 4'hF, 9'h0);
            rse_v    = 4'b0001;
            step();
        end
        idle();
        issue_rdy = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("t7_issue_v", 64'(issue_v), 64'd0);
        check("t7_busy", 64'(busy), 64'd0);
        check_ent("t7_issue_o", issue_o, '0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        issue_rdy = 1'b0;
        rse_i[0]  = mk(12, 4'hF, 9'h0);
        rse_v     = 4'b0001;
        step();
        idle();
        #1;
        check("t7_reaccept", 64'(issue_o.rndx), 64'd12);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qupls4_reservation_station.md
# qupls4_reservation_station

Per-functional-unit reservation station on the receiving end of the instruction dispatcher's four-lane `rse` output. It accepts at most one dispatched entry per cycle tagged with its own functional-unit number, holds up to `NENTRIES` entries, and captures missing operands from writeback buses by physical-register tag. It issues the oldest fully-ready entry to its functional unit over a valid/ready handshake, and drives the dispatcher's `busy` bit for that unit.

## Interface
- `FUNCUNIT`, 4'd0: functional-unit number this station answers to; matched against `rse_i[k].funcunit`.
- `NENTRIES`, 4: station depth, 2..8.
- `NWB`, 4: number of writeback buses snooped.
- `WID`, 64: operand width.

Ports, clock and reset first:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-low reset.
- `rse_i`  in  4×`reservation_station_entry_t`: dispatcher lanes.
- `rse_v`  in  4: per-lane valid (`rob_dispatched_v`).
- `stomp`  in  `ROB_ENTRIES`: flush mask indexed by ROB index.
- `wb_v`  in  `NWB`: writeback valid.
- `wb_preg`  in  `NWB`×9: writeback physical register.
- `wb_val`  in  `NWB`×`WID`: writeback value.
- `busy`  out  1: dispatcher must not target this unit.
- `issue_o`  out  `reservation_station_entry_t`: entry presented to the functional unit, all args valid.
- `issue_v`  out  1: `issue_o` valid.
- `issue_rdy`  in  1: functional unit accepts.

## Operation
- Dispatch match: lane k hits when `rse_v[k] && rse_i[k].funcunit==FUNCUNIT`. The lowest-numbered hit is accepted. Multiple hits are a protocol error: a simulation assertion fires, and only the lowest lane is taken.
- Allocation: the accepted entry goes into the lowest free slot at the clock edge.
- Dispatch-cycle capture: for each argX with `argX_v==0`, if any `wb_v[j] && wb_preg[j]==argX[8:0]` in the dispatch cycle, the entry is stored with `wb_val[j]` and `argX_v=1`.
- Wakeup: every resident invalid arg compares `argX[8:0]` against all `NWB` buses each cycle and captures on a match. Lowest j wins a duplicate match.
- Ready: a slot is valid, argA/B/C/D_v are all 1, and `stomp[rndx]==0`.
- Select: the oldest ready slot, by age matrix. `issue_v` is asserted whenever any slot is ready. `issue_o`/`issue_v` are combinational from registered state.
- Handshake: when `issue_v && issue_rdy`, the selected slot is freed at the edge. While `issue_rdy` is low, `issue_o` may change only if an older entry becomes ready.
- Stomp: any valid slot with `stomp[rndx]==1` is freed at the edge and is never issued. A stomped lane at dispatch is still accepted; the dispatcher has already converted it to a NOP.
- Free count: `free = NENTRIES - occupied`.
- Busy:
  - `busy = (free==0) || (free==1 && dispatch_hit)`.
  - This covers the one-cycle dispatcher register lag.
  - Freeing by issue or stomp is not credited in the same cycle.
- Reset (`rst`=0): all slots invalid, age matrix cleared, `busy=0`, `issue_v=0`, `issue_o=0`.

## Timing
- Dispatch at edge N: entry resident in cycle N+1. If all args are valid, `issue_v=1` in cycle N+1 (1-cycle minimum latency).
- Writeback in cycle N matching a resident tag: arg valid, and the entry ready if otherwise complete, in cycle N+1.
- Issue handshake at edge N: slot free in N+1, and `busy` reflects it in N+1.
- Simultaneous dispatch and issue when full-minus-one: both take effect. `busy` stays 1 that cycle.
- Simultaneous stomp and `issue_rdy` on the selected slot: the slot is excluded from ready, so the next-oldest ready slot (if any) issues.
- Reset mid-operation: all state discarded asynchronously. No partial issue.

## Configuration
- `QUPLS4_RS_AGE_ORDER_EN` defined: the age matrix selects the oldest ready slot.
- Undefined: no age matrix; the lowest-index ready slot issues. All other behaviour is identical, and the age-dependent test runs only when the macro is defined.

## Structure
- `Qupls4_pkg` additions:
  - `rs_wb_bus_t` {v, preg[8:0], val[WID-1:0]};
  - `RS_NENTRIES_DEF`.
- `reservation_station_entry_t` and `ROB_ENTRIES` are reused as-is.
- Sub-module: `qupls4_rs_age_matrix`.
  - Row set on allocate, column clear on free.
  - Outputs a one-hot oldest among a request vector.

## Test plan
- Dispatch lane 2, `funcunit`=FUNCUNIT, all args valid, `issue_rdy`=1 → `issue_v`=1 next cycle, `issue_o.rndx` matches, slot freed one cycle later.
- Entry with argB invalid (preg 9'h05a); `wb_preg[1]`=9'h05a, `wb_val`=64'hDEAD_BEEF two cycles later → `issue_v` rises the cycle after writeback with `argB`=64'hDEAD_BEEF.
- Writeback of preg 9'h011 in the same cycle as dispatch of an entry waiting on 9'h011 → entry issues the next cycle; the operand is not lost.
- `issue_rdy`=0, dispatch 4 entries (NENTRIES=4) → `busy`=1 from the cycle the 3rd entry is accepted while the 4th hits; no entry is overwritten. Raise `issue_rdy` → `busy` falls one cycle after the first handshake.
- Two ready entries with rndx 7 then 3, `QUPLS4_RS_AGE_ORDER_EN` set → rndx 7 issues first. Assert `stomp[3]` → the second entry is freed and never issued.
- Assert `rst`=0 with 3 resident entries mid-handshake → `issue_v`=0 and `busy`=0 immediately; after release, the station accepts into slot 0.
